// File: rtl/ets_system.sv
// ets_system: three-channel equivalent-time-sampling core with MMCM phase stepping
//    shifting_clk/reset      : functional clock, async active-high reset
//    sys_clk -> ps_clk       : MMCM DPS clock, forwarded combinationally
//    ps_en/ps_incdec/ps_done : MMCM dynamic phase-shift handshake (always increments)
//    en                      : sweep enable, sampled in IDLE and WAIT only
//    CMP_DATA_x, T_x, A_x    : comparator input, window length, hit count
//    waddr_x/w_occur_x/w_ready_x             : result memory write port
//    raddr_x/r_occur_x/rdata_x/r_valid_x     : result memory read port
module ets_system (
   input  logic        shifting_clk,
   input  logic        reset,
   input  logic        sys_clk,
   output logic        ps_clk,
   output logic        ps_en,
   output logic        ps_incdec,
   input  logic        ps_done,
   input  logic        en,
   input  logic        CMP_DATA_ref,
   input  logic        CMP_DATA_S11,
   input  logic        CMP_DATA_S21,
   input  logic [7:0]  T_ref,
   input  logic [7:0]  T_S11,
   input  logic [7:0]  T_S21,
   output logic [15:0] A_ref,
   output logic [15:0] A_S11,
   output logic [15:0] A_S21,
   input  logic [9:0]  waddr_ref,
   input  logic [9:0]  waddr_S11,
   input  logic [9:0]  waddr_S21,
   input  logic        w_occur_ref,
   input  logic        w_occur_S11,
   input  logic        w_occur_S21,
   output logic        w_ready_ref,
   output logic        w_ready_S11,
   output logic        w_ready_S21,
   input  logic [9:0]  raddr_ref,
   input  logic [9:0]  raddr_S11,
   input  logic [9:0]  raddr_S21,
   input  logic        r_occur_ref,
   input  logic        r_occur_S11,
   input  logic        r_occur_S21,
   output logic [31:0] rdata_ref,
   output logic [31:0] rdata_S11,
   output logic [31:0] rdata_S21,
   output logic        r_valid_ref,
   output logic        r_valid_S11,
   output logic        r_valid_S21
);
   typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, SHIFT, WAIT} state_t;
   state_t state_q, state_d;
   logic [9:0]        step_q;
   logic [7:0]        c_q, tmax01, tmax;
   logic [2:0][7:0]   t_in, tl_q, a_q;
   logic [2:0][9:0]   waddr, raddr;
   logic [2:0][31:0]  rdata_q;
   logic [2:0]        cmp, w_occur, r_occur, w_ready_q, r_valid_q;
   logic [31:0]       mem [3][1024];

   assign cmp     = {CMP_DATA_S21, CMP_DATA_S11, CMP_DATA_ref};
   assign t_in    = {T_S21, T_S11, T_ref};
   assign waddr   = {waddr_S21, waddr_S11, waddr_ref};
   assign raddr   = {raddr_S21, raddr_S11, raddr_ref};
   assign w_occur = {w_occur_S21, w_occur_S11, w_occur_ref};
   assign r_occur = {r_occur_S21, r_occur_S11, r_occur_ref};
   assign tmax01  = tl_q[0] > tl_q[1] ? tl_q[0] : tl_q[1];
   assign tmax    = tmax01 > tl_q[2] ? tmax01 : tl_q[2];

   assign A_ref = {8'b0, a_q[0]};
   assign A_S11 = {8'b0, a_q[1]};
   assign A_S21 = {8'b0, a_q[2]};
   assign {w_ready_S21, w_ready_S11, w_ready_ref} = w_ready_q;
   assign {r_valid_S21, r_valid_S11, r_valid_ref} = r_valid_q;
   assign rdata_ref = rdata_q[0];
   assign rdata_S11 = rdata_q[1];
   assign rdata_S21 = rdata_q[2];

   always_ff @(posedge shifting_clk or posedge reset)
      if (reset) state_q <= IDLE;
      else state_q <= state_d;

   // CLEAR decides on the live T inputs since they are latched on that same edge
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = en ? CLEAR : IDLE;
         CLEAR:   state_d = (T_ref | T_S11 | T_S21) == 8'd0 ? SHIFT : ACCUM;
         ACCUM:   state_d = c_q == tmax - 8'd1 ? SHIFT : ACCUM;
         SHIFT:   state_d = WAIT;
         WAIT:    state_d = ps_done ? (en ? CLEAR : IDLE) : WAIT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ps_clk    = sys_clk;
      ps_incdec = 1'b1;
      ps_en     = state_q == SHIFT;
   end

   always_ff @(posedge shifting_clk or posedge reset) begin
      if (reset) begin
         step_q    <= '0;
         c_q       <= '0;
         tl_q      <= '0;
         a_q       <= '0;
         w_ready_q <= '0;
         r_valid_q <= '0;
         rdata_q   <= '0;
      end else begin
         c_q       <= state_q == CLEAR ? 8'd0 : state_q == ACCUM ? c_q + 8'd1 : c_q;
         step_q    <= state_q == WAIT && ps_done ? step_q + 10'd1 : step_q;
         tl_q      <= state_q == CLEAR ? t_in : tl_q;
         w_ready_q <= w_occur;
         r_valid_q <= r_occur;
         for (int i = 0; i < 3; i++) begin
            if (state_q == CLEAR) a_q[i] <= '0;
            else if (state_q == ACCUM && c_q < tl_q[i] && cmp[i]) a_q[i] <= a_q[i] + 8'd1;
            if (r_occur[i]) rdata_q[i] <= mem[i][raddr[i]];
         end
      end
   end

   // memory is not reset; a same-edge read sees the old word (read-first)
   always_ff @(posedge shifting_clk)
      for (int i = 0; i < 3; i++)
         if (w_occur[i]) mem[i][waddr[i]] <= {6'b0, step_q, 8'b0, a_q[i]};
endmodule

// File: tb/tb_ets_system.sv
// tb_ets_system: randomized bench for ets_system against a step-level timeline model
module tb_ets_system;
   logic        shifting_clk = 1'b0, sys_clk = 1'b0, reset = 1'b1;
   logic        ps_done = 1'b0, en = 1'b0;
   logic        ps_clk, ps_en, ps_incdec;
   logic        CMP_DATA_ref = 1'b0, CMP_DATA_S11 = 1'b0, CMP_DATA_S21 = 1'b0;
   logic [7:0]  T_ref = '0, T_S11 = '0, T_S21 = '0;
   logic [15:0] A_ref, A_S11, A_S21;
   logic [9:0]  waddr_ref = '0, waddr_S11 = '0, waddr_S21 = '0;
   logic [9:0]  raddr_ref = '0, raddr_S11 = '0, raddr_S21 = '0;
   logic        w_occur_ref = 1'b0, w_occur_S11 = 1'b0, w_occur_S21 = 1'b0;
   logic        r_occur_ref = 1'b0, r_occur_S11 = 1'b0, r_occur_S21 = 1'b0;
   logic        w_ready_ref, w_ready_S11, w_ready_S21;
   logic        r_valid_ref, r_valid_S11, r_valid_S21;
   logic [31:0] rdata_ref, rdata_S11, rdata_S21;

   logic [2:0][15:0] a_port;
   logic [2:0][31:0] rd_port;
   logic [2:0]       wr_port, rv_port;
   assign a_port  = {A_S21, A_S11, A_ref};
   assign rd_port = {rdata_S21, rdata_S11, rdata_ref};
   assign wr_port = {w_ready_S21, w_ready_S11, w_ready_ref};
   assign rv_port = {r_valid_S21, r_valid_S11, r_valid_ref};

   int          n_chk = 0, n_fail = 0, nsteps = 0;
   int          a_exp [3];
   logic [9:0]  step_exp = '0;
   logic [31:0] mem_m [3][1024];
   bit          wr_m [3][1024];
   bit          rk [3];
   logic [31:0] re [3];
   bit   [2:0]  pw = '0, pr = '0, wq = '0, rq = '0;
   logic [2:0][9:0] wa = '0, ra = '0;
   bit          rnd_mem = 1'b1;

   ets_system dut (
      .shifting_clk(shifting_clk), .reset(reset), .sys_clk(sys_clk),
      .ps_clk(ps_clk), .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done), .en(en),
      .CMP_DATA_ref(CMP_DATA_ref), .CMP_DATA_S11(CMP_DATA_S11), .CMP_DATA_S21(CMP_DATA_S21),
      .T_ref(T_ref), .T_S11(T_S11), .T_S21(T_S21),
      .A_ref(A_ref), .A_S11(A_S11), .A_S21(A_S21),
      .waddr_ref(waddr_ref), .waddr_S11(waddr_S11), .waddr_S21(waddr_S21),
      .w_occur_ref(w_occur_ref), .w_occur_S11(w_occur_S11), .w_occur_S21(w_occur_S21),
      .w_ready_ref(w_ready_ref), .w_ready_S11(w_ready_S11), .w_ready_S21(w_ready_S21),
      .raddr_ref(raddr_ref), .raddr_S11(raddr_S11), .raddr_S21(raddr_S21),
      .r_occur_ref(r_occur_ref), .r_occur_S11(r_occur_S11), .r_occur_S21(r_occur_S21),
      .rdata_ref(rdata_ref), .rdata_S11(rdata_S11), .rdata_S21(rdata_S21),
      .r_valid_ref(r_valid_ref), .r_valid_S11(r_valid_S11), .r_valid_S21(r_valid_S21)
   );

   always #5 shifting_clk = ~shifting_clk;
   always #3 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      a_exp = '{0, 0, 0};
      step_exp = '0;
      pw = '0;
      pr = '0;
      for (int i = 0; i < 3; i++) begin
         rk[i] = 1'b1;
         re[i] = '0;
      end
   endtask

   // check the current cycle, issue memory strobes, advance to #1 after the next edge
   task automatic cyc(input bit exp_en);
      check("ps_en", {31'b0, ps_en}, {31'b0, exp_en});
      check("ps_incdec", {31'b0, ps_incdec}, 32'd1);
      check("ps_clk", {31'b0, ps_clk}, {31'b0, sys_clk});
      for (int i = 0; i < 3; i++) begin
         check($sformatf("A%0d", i), {16'b0, a_port[i]}, 32'(a_exp[i]));
         check($sformatf("w_ready%0d", i), {31'b0, wr_port[i]}, {31'b0, pw[i]});
         check($sformatf("r_valid%0d", i), {31'b0, rv_port[i]}, {31'b0, pr[i]});
         if (rk[i]) check($sformatf("rdata%0d", i), rd_port[i], re[i]);
         if (rnd_mem) begin
            wq[i] = $urandom_range(0, 3) == 0;
            rq[i] = $urandom_range(0, 2) == 0;
            wa[i] = 10'($urandom_range(0, 7));
            ra[i] = 10'($urandom_range(0, 7));
         end
         if (rq[i]) begin
            rk[i] = wr_m[i][ra[i]];
            re[i] = mem_m[i][ra[i]];
         end
         if (wq[i]) begin
            mem_m[i][wa[i]] = {6'b0, step_exp, 16'(a_exp[i])};
            wr_m[i][wa[i]] = 1'b1;
         end
      end
      pw = wq;
      pr = rq;
      {w_occur_S21, w_occur_S11, w_occur_ref} = wq;
      {r_occur_S21, r_occur_S11, r_occur_ref} = rq;
      {waddr_S21, waddr_S11, waddr_ref} = wa;
      {raddr_S21, raddr_S11, raddr_ref} = ra;
      @(posedge shifting_clk);
      #1;
      wq = '0;
      rq = '0;
      {w_occur_S21, w_occur_S11, w_occur_ref} = '0;
      {r_occur_S21, r_occur_S11, r_occur_ref} = '0;
   endtask

   task automatic noise();
      {CMP_DATA_S21, CMP_DATA_S11, CMP_DATA_ref} = 3'($urandom);
      ps_done = 1'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         noise();
         en = 1'b0;
         cyc(0);
      end
   endtask

   task automatic start();
      noise();
      en = 1'b1;
      cyc(0);
   endtask

   // one sweep step from the CLEAR cycle; mode 0 random hits, 1 all hits, 2 alternating from 1
   task automatic run_step(input int t0, t1, t2, input int mode, input int k, input bit en_next);
      int t [3];
      int m;
      logic [2:0] c;
      t[0] = t0;
      t[1] = t1;
      t[2] = t2;
      m = t0 > t1 ? t0 : t1;
      m = m > t2 ? m : t2;
      T_ref = 8'(t0);
      T_S11 = 8'(t1);
      T_S21 = 8'(t2);
      noise();
      en = 1'($urandom);
      cyc(0);
      a_exp = '{0, 0, 0};
      for (int j = 0; j < m; j++) begin
         c = mode == 1 ? 3'b111 : mode == 2 ? {3{j % 2 == 0}} : 3'($urandom);
         {CMP_DATA_S21, CMP_DATA_S11, CMP_DATA_ref} = c;
         {T_S21, T_S11, T_ref} = 24'($urandom);
         ps_done = 1'($urandom);
         en = 1'($urandom);
         cyc(0);
         for (int i = 0; i < 3; i++) if (j < t[i] && c[i]) a_exp[i]++;
      end
      noise();
      en = 1'($urandom);
      cyc(1);
      for (int w = 1; w <= k; w++) begin
         noise();
         ps_done = w == k;
         en = en_next;
         cyc(0);
      end
      ps_done = 1'b0;
      step_exp++;
      nsteps++;
   endtask

   initial begin
      bit e;
      model_reset();
      repeat (3) @(posedge shifting_clk);
      #1;
      check("rst_ps_en", {31'b0, ps_en}, 32'd0);
      check("rst_ps_incdec", {31'b0, ps_incdec}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         check("rst_A", {16'b0, a_port[i]}, 32'd0);
         check("rst_w_ready", {31'b0, wr_port[i]}, 32'd0);
         check("rst_r_valid", {31'b0, rv_port[i]}, 32'd0);
         check("rst_rdata", rd_port[i], 32'd0);
      end
      #2 check("rst_ps_clk", {31'b0, ps_clk}, {31'b0, sys_clk});
      @(posedge shifting_clk);
      #1 reset = 1'b0;
      idle(3);
      start();
      run_step(11, 11, 11, 1, 1, 1);
      run_step(11, 11, 11, 1, 1, 1);
      run_step(11, 11, 11, 1, 1, 0);
      rnd_mem = 1'b0;
      idle(2);
      check("full_A_ref", {16'b0, A_ref}, 32'd11);
      wq[0] = 1'b1;
      wa[0] = 10'd7;
      idle(1);
      rq[0] = 1'b1;
      ra[0] = 10'd7;
      idle(1);
      idle(1);
      check("wr_rd_word", rdata_ref, 32'h0003000B);
      rnd_mem = 1'b1;
      start();
      run_step(11, 5, 0, 2, 1, 0);
      idle(2);
      check("alt_A_ref", {16'b0, A_ref}, 32'd6);
      check("alt_A_S11", {16'b0, A_S11}, 32'd3);
      check("alt_A_S21", {16'b0, A_S21}, 32'd0);
      start();
      for (int s = 0; s < 40; s++) begin
         e = $urandom_range(0, 3) != 0;
         run_step($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12), 0,
                  $urandom_range(1, 4), e);
         if (!e) begin
            idle($urandom_range(1, 3));
            start();
         end
      end
      while (nsteps < 1030)
         run_step($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 0, 1, 1);
      run_step(6, 3, 9, 0, 40, 1);
      run_step(12, 7, 4, 0, 2, 0);
      idle(20);
      rnd_mem = 1'b0;
      wq[1] = 1'b1;
      wa[1] = 10'd5;
      idle(1);
      wq[1] = 1'b1;
      wa[1] = 10'd5;
      rq[1] = 1'b1;
      ra[1] = 10'd5;
      idle(1);
      idle(1);
      rq[1] = 1'b1;
      ra[1] = 10'd5;
      idle(1);
      idle(1);
      rnd_mem = 1'b1;
      start();
      T_ref = 8'd10;
      T_S11 = 8'd10;
      T_S21 = 8'd10;
      noise();
      cyc(0);
      a_exp = '{0, 0, 0};
      for (int j = 0; j < 4; j++) begin
         {CMP_DATA_S21, CMP_DATA_S11, CMP_DATA_ref} = 3'b111;
         if (j == 3) begin
            rnd_mem = 1'b0;
            wq = 3'b111;
            rq = 3'b111;
         end
         cyc(0);
         for (int i = 0; i < 3; i++) a_exp[i]++;
      end
      reset = 1'b1;
      #1;
      check("mid_rst_ps_en", {31'b0, ps_en}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("mid_rst_A", {16'b0, a_port[i]}, 32'd0);
         check("mid_rst_w_ready", {31'b0, wr_port[i]}, 32'd0);
         check("mid_rst_r_valid", {31'b0, rv_port[i]}, 32'd0);
         check("mid_rst_rdata", rd_port[i], 32'd0);
      end
      model_reset();
      @(posedge shifting_clk);
      #1 reset = 1'b0;
      rnd_mem = 1'b1;
      idle(15);
      start();
      run_step(5, 9, 2, 0, 2, 0);
      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
